seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning datapath width; legal values are powers of two, 8 or greater.
REQ-002 The block SHALL have derived localparam SW = log2(N), meaning shift-amount width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset that is synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port opcode, input, 4 bits: operation select.
REQ-008 The block SHALL have ports operandA and operandB, input, N bits each: the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result and flags are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port result, output, N bits: the registered result.
REQ-012 The block SHALL have ports C_Flag, O_Flag, N_Flag and Z_Flag, output, 1 bit each: registered flags.

Function
REQ-013 The block SHALL use opcodes 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL, 9 DIVU, 10 REMU; opcodes 11-15 are illegal.
REQ-014 The block SHALL implement a state machine with states IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 The block SHALL accept a request on the edge where in_valid and in_ready are both 1, and SHALL capture operands and opcode on that edge.
REQ-017 For opcodes 0-7 and illegal opcodes, the block SHALL go IDLE->DONE, so out_valid is asserted 1 cycle after acceptance.
REQ-018 For opcodes 8-10, the block SHALL go IDLE->BUSY, stay in BUSY exactly N cycles (iteration counter 0..N-1), then go to DONE, so out_valid is asserted N+1 cycles after acceptance.
REQ-019 In DONE, out_valid SHALL be 1, and result and flags SHALL be held stable until out_ready=1; on that edge the block SHALL return to IDLE.
REQ-020 in_valid SHALL be ignored in BUSY and DONE, with no pipelining and no overlap between operations.
REQ-021 ADD and SUB SHALL compute A+B and A+~B+1 in N+1 bits; C SHALL be bit N (for SUB, C=1 means no borrow); O SHALL be the signed overflow.
REQ-022 Shifts SHALL use B[SW-1:0] only; SRA SHALL replicate A[N-1].
REQ-023 MUL SHALL be unsigned shift-add; result SHALL be the low N bits of the product; C SHALL be 1 if the high N bits are nonzero.
REQ-024 DIVU and REMU SHALL use unsigned restoring division, one quotient bit per cycle.
REQ-025 Divide by zero SHALL give DIVU result all-ones, REMU result equal to A, and C=1, and SHALL still take N+1 cycles.
REQ-026 For logic ops, shifts, illegal opcodes, and DIVU/REMU with a nonzero divisor, C SHALL be 0; O SHALL be 0 for every op except ADD and SUB.
REQ-027 Illegal opcodes SHALL give result 0.
REQ-028 For every op, N_Flag SHALL equal result[N-1] and Z_Flag SHALL equal (result==0).
REQ-029 Simultaneous out_ready=1 and in_valid=1 in DONE SHALL not accept the request; the request is accepted at the earliest on the following cycle, in IDLE.

Reset
REQ-030 When rst_n=0 at a clock edge, the block SHALL force state IDLE, in_ready=1, out_valid=0, result=0, all flags 0, and iteration counter 0.
REQ-031 Reset during BUSY or DONE SHALL abort the operation silently, produce no out_valid pulse, and discard the pending result.
REQ-032 Outputs SHALL be registered; result and flags SHALL not be combinational from the inputs.

Structure
REQ-033 Shared package alu_pkg SHALL hold the opcode enum (4-bit), the state enum, and the opcode-class helper (single-cycle vs iterative).
REQ-034 The single sub-module SHALL be alu_muldiv: iterative unsigned multiplier/divider with start/done, parameter N, and outputs low word, high-nonzero and div-by-zero.
REQ-035 Single-cycle ops and flag generation SHALL live in seq_alu.
REQ-036 The target implementation size SHALL be 150-300 lines total.

Verification (N=32)
REQ-037 The bench SHALL check that ADD 0x7FFFFFFF+0x00000001 gives out_valid 1 cycle after acceptance, result 0x80000000, O=1, N=1, C=0, Z=0.
REQ-038 The bench SHALL check that SUB 5-5 gives result 0, Z=1, C=1, O=0; and that SUB 3-5 gives result 0xFFFFFFFE, C=0, N=1.
REQ-039 The bench SHALL check that MUL 0x00010000*0x00010000 gives result 0, C=1, Z=1, with out_valid exactly 33 cycles after acceptance and in_ready=0 throughout.
REQ-040 The bench SHALL check that DIVU 100/7 gives 14; that REMU 100/7 gives 2; that DIVU 9/0 gives 0xFFFFFFFF with C=1; and that REMU 9/0 gives 9 with C=1.
REQ-041 The bench SHALL hold out_ready=0 for 5 cycles after out_valid with in_valid=1 and a new operation, and check that the result is held, in_ready=0, and the new request is not taken until the cycle after the IDLE return.
REQ-042 The bench SHALL drop rst_n=0 for 1 cycle at BUSY cycle 10 of a DIVU, and check that out_valid=0, in_ready=1, result=0 on the next cycle, and that a following ADD 2+3 returns 5 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for seq_alu: opcode and FSM state enums, plus the opcode-class
// helper that separates single-cycle operations from the iterative ones.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_MUL  = 4'd8,
        OP_DIVU = 4'd9,
        OP_REMU = 4'd10
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for operations that run on the iterative multiplier/divider.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : load operands and begin (one-cycle pulse)
//   op           : OP_MUL, OP_DIVU or OP_REMU
//   a, b         : operands (multiplicand/dividend, multiplier/divisor)
//   done_c       : high during the last iteration cycle
//   lo_c         : low word as it will be after the current iteration
//                  (product low, quotient or remainder)
//   hi_nz_c      : high product word nonzero, after the current iteration
//   div_zero     : divisor was zero (registered at start)
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  opcode_t      op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done_c,
    output logic [N-1:0] lo_c,
    output logic         hi_nz_c,
    output logic         div_zero
);

    localparam int unsigned SW = $clog2(N);

    logic          busy_q;
    logic [SW-1:0] cnt_q;
    logic [N-1:0]  acc_q;   // product high word / partial remainder
    logic [N-1:0]  q_q;     // multiplier shifting out / quotient shifting in
    logic [N-1:0]  b_q;
    opcode_t       op_q;

    logic [N-1:0]  acc_n;
    logic [N-1:0]  q_n;
    logic [N:0]    sum_w;
    logic [N:0]    rem_sh;

    // One iteration step.
    always_comb begin
        acc_n  = acc_q;
        q_n    = q_q;
        sum_w  = '0;
        rem_sh = '0;
        if (op_q == OP_MUL) begin
            // Shift-add, LSB first: {carry, acc, q} shifts right one place.
            sum_w        = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
            {acc_n, q_n} = {sum_w, q_q[N-1:1]};
        end else begin
            // Restoring step: bring in next dividend bit, subtract if it fits.
            // A zero divisor always "fits", giving all-ones quotient and a
            // remainder that ends up equal to the dividend.
            rem_sh = {acc_q, q_q[N-1]};
            if (rem_sh >= {1'b0, b_q}) begin
                acc_n = rem_sh[N-1:0] - b_q;
                q_n   = {q_q[N-2:0], 1'b1};
            end else begin
                acc_n = rem_sh[N-1:0];
                q_n   = {q_q[N-2:0], 1'b0};
            end
        end
    end

    assign done_c  = busy_q && (cnt_q == SW'(N - 1));
    assign lo_c    = (op_q == OP_REMU) ? acc_n : q_n;
    assign hi_nz_c = (acc_n != '0);

    // Operand load and iteration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_MUL;
            div_zero <= 1'b0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= a;
            b_q      <= b;
            op_q     <= op;
            div_zero <= (b == '0);
        end else if (busy_q) begin
            acc_q <= acc_n;
            q_q   <= q_n;
            cnt_q <= cnt_q + SW'(1);
            if (done_c) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake on both sides. Single-cycle ops
// complete one cycle after acceptance; MUL/DIVU/REMU take N+1 cycles.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid, in_ready   : request handshake (ready only in IDLE)
//   opcode               : operation select (11..15 illegal, result 0)
//   operandA, operandB   : operands
//   out_valid, out_ready : response handshake (result held until accepted)
//   result               : registered result
//   C_Flag/O_Flag/N_Flag/Z_Flag : registered carry, overflow, negative, zero
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   opcode,
    input  logic [N-1:0] operandA,
    input  logic [N-1:0] operandB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         C_Flag,
    output logic         O_Flag,
    output logic         N_Flag,
    output logic         Z_Flag
);

    localparam int unsigned SW = $clog2(N);

    state_t        state_q;
    state_t        state_d;
    opcode_t       op_in;
    opcode_t       op_q;
    logic          accept;
    logic          iter_op;

    logic [N:0]    add_w;
    logic [N:0]    sub_w;
    logic [SW-1:0] shamt;
    logic [N-1:0]  alu_res_c;
    logic          alu_c_c;
    logic          alu_o_c;

    logic          md_done_c;
    logic [N-1:0]  md_lo_c;
    logic          md_hi_nz_c;
    logic          md_div_zero;

    assign op_in   = opcode_t'(opcode);
    assign iter_op = is_iterative(opcode);
    assign accept  = (state_q == ST_IDLE) && in_valid;

    alu_muldiv #(.N(N)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept && iter_op),
        .op       (op_in),
        .a        (operandA),
        .b        (operandB),
        .done_c   (md_done_c),
        .lo_c     (md_lo_c),
        .hi_nz_c  (md_hi_nz_c),
        .div_zero (md_div_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in_valid is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = iter_op ? ST_BUSY : ST_DONE;
            ST_BUSY: if (md_done_c) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Single-cycle datapath, evaluated on the live operands at acceptance.
    always_comb begin
        add_w     = {1'b0, operandA} + {1'b0, operandB};
        sub_w     = {1'b0, operandA} + {1'b0, ~operandB} + (N+1)'(1);
        shamt     = operandB[SW-1:0];
        alu_res_c = '0;
        alu_c_c   = 1'b0;
        alu_o_c   = 1'b0;
        case (op_in)
            OP_ADD: begin
                alu_res_c = add_w[N-1:0];
                alu_c_c   = add_w[N];
                alu_o_c   = (operandA[N-1] == operandB[N-1]) &&
                            (add_w[N-1] != operandA[N-1]);
            end
            OP_SUB: begin
                alu_res_c = sub_w[N-1:0];
                alu_c_c   = sub_w[N];
                alu_o_c   = (operandA[N-1] != operandB[N-1]) &&
                            (sub_w[N-1] != operandA[N-1]);
            end
            OP_AND:  alu_res_c = operandA & operandB;
            OP_OR:   alu_res_c = operandA | operandB;
            OP_XOR:  alu_res_c = operandA ^ operandB;
            OP_SLL:  alu_res_c = operandA << shamt;
            OP_SRL:  alu_res_c = operandA >> shamt;
            OP_SRA:  alu_res_c = N'($signed(operandA) >>> shamt);
            default: alu_res_c = '0;
        endcase
    end

    // Handshake outputs, captured opcode, result and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            op_q      <= OP_ADD;
            result    <= '0;
            C_Flag    <= 1'b0;
            O_Flag    <= 1'b0;
            N_Flag    <= 1'b0;
            Z_Flag    <= 1'b0;
        end else begin
            in_ready  <= (state_d == ST_IDLE);
            out_valid <= (state_d == ST_DONE);
            if (accept) begin
                op_q <= op_in;
            end
            if (accept && !iter_op) begin
                result <= alu_res_c;
                C_Flag <= alu_c_c;
                O_Flag <= alu_o_c;
                N_Flag <= alu_res_c[N-1];
                Z_Flag <= (alu_res_c == '0);
            end else if ((state_q == ST_BUSY) && md_done_c) begin
                // Last iteration: take the step output directly.
                result <= md_lo_c;
                C_Flag <= (op_q == OP_MUL) ? md_hi_nz_c : md_div_zero;
                O_Flag <= 1'b0;
                N_Flag <= md_lo_c[N-1];
                Z_Flag <= (md_lo_c == '0);
            end
        end
    end

endmodule
